ddr_wr_arb: RTL and testbench

Parametrised N-channel write arbiter between the per-source write cells and the single DDR write port, running entirely in the DDR controller clock domain. Replaces the fixed three-plus-one write multiplexer with a registered grant held for a whole burst, selectable priority channel, fill-level arbitration with round-robin tie-break, and starvation protection. Upstream are the write cells and the overlay write path; downstream is the DDR write-burst interface.

---
 rtl/ddr_wr_arb_pkg.sv | 17 +
 rtl/ddr_wr_arb_pick.sv | 70 +++++++
 rtl/ddr_wr_arb.sv | 175 +++++++++++++++++
 tb/tb_ddr_wr_arb.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_wr_arb_pkg.sv
// Shared types and widths for the DDR write arbiter.
package ddr_wr_arb_pkg;

    // Largest supported channel count sets the index width.
    localparam int unsigned CH_NUM_MAX = 8;
    localparam int unsigned CH_IDX_W   = $clog2(CH_NUM_MAX);

    // Starve counters saturate at STARVE_MAX, which must fit in this width.
    localparam int unsigned STARVE_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ddr_wr_arb_pick.sv
// Combinational winner selection for the DDR write arbiter.
// Ports:
//   req       per-channel request
//   fill      per-channel pending-burst count (flat)
//   starve    per-channel lost-arbitration counters
//   last_idx  index of the last granted channel (round-robin origin)
//   any_c     some channel is requesting
//   win_oh_c  one-hot winner
//   win_idx_c winner index
module ddr_wr_arb_pick
    import ddr_wr_arb_pkg::*;
#(
    parameter int unsigned CH_NUM     = 4,
    parameter int unsigned CNT_WIDTH  = 6,
    parameter int unsigned PRIO_CH    = 3,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic [CH_NUM-1:0]                req,
    input  logic [CH_NUM*CNT_WIDTH-1:0]      fill,
    input  logic [CH_NUM-1:0][STARVE_W-1:0]  starve,
    input  logic [CH_IDX_W-1:0]              last_idx,
    output logic                             any_c,
    output logic [CH_NUM-1:0]                win_oh_c,
    output logic [CH_IDX_W-1:0]              win_idx_c
);

    // PRIO_CH == CH_NUM (or larger) disables the priority channel.
    localparam bit          PRIO_EN  = (PRIO_CH < CH_NUM);
    localparam int unsigned PRIO_IDX = PRIO_EN ? PRIO_CH : 0;

    // Priority, then starvation, then max fill scanned in round-robin order.
    always_comb begin
        logic                 found;
        logic                 fill_found;
        logic [CNT_WIDTH-1:0] best;
        int                   j;
        found      = 1'b0;
        fill_found = 1'b0;
        best       = '0;
        j          = 0;
        win_idx_c  = '0;

        if (PRIO_EN && req[PRIO_IDX]) begin
            win_idx_c = CH_IDX_W'(PRIO_IDX);
            found     = 1'b1;
        end

        for (int i = 0; i < int'(CH_NUM); i++) begin
            if (!found && req[i] && (starve[i] == STARVE_W'(STARVE_MAX))) begin
                win_idx_c = CH_IDX_W'(i);
                found     = 1'b1;
            end
        end

        // Strict '>' keeps the first channel in rotation order on ties.
        for (int k = 1; k <= int'(CH_NUM); k++) begin
            j = (int'(last_idx) + k) % int'(CH_NUM);
            if (!found && req[j] &&
                (!fill_found || (fill[j*CNT_WIDTH +: CNT_WIDTH] > best))) begin
                best       = fill[j*CNT_WIDTH +: CNT_WIDTH];
                fill_found = 1'b1;
                win_idx_c  = CH_IDX_W'(j);
            end
        end

        any_c    = |req;
        win_oh_c = any_c ? (CH_NUM'(1) << win_idx_c) : '0;
    end

endmodule

// File: rtl/ddr_wr_arb.sv
// N-channel write arbiter in front of the single DDR write-burst port.
// Grant is registered and held from request through the data phase.
// Ports:
//   ddr_clk, ddr_rst           clock, synchronous active-high reset
//   ch_wreq/waddr/wr_len/wdata per-channel burst request and payload
//   ch_fill                    per-channel pending-burst count
//   ch_wack                    one-cycle accept pulse to the granted channel
//   ch_wdata_req               data-beat pull routed to the granted channel
//   ch_grant                   one-hot grant
//   ddr_wreq/waddr/wr_len      registered burst request to DDR
//   ddr_wrdy/wdata_req/wdone   DDR handshakes
//   ddr_wdata                  data of the granted channel
//   arb_busy                   burst in progress
module ddr_wr_arb
    import ddr_wr_arb_pkg::*;
#(
    parameter int unsigned CH_NUM     = 4,
    parameter int unsigned ADDR_WIDTH = 27,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned DQ_WIDTH   = 32,
    parameter int unsigned CNT_WIDTH  = 6,
    parameter int unsigned PRIO_CH    = 3,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                             ddr_clk,
    input  logic                             ddr_rst,
    input  logic [CH_NUM-1:0]                ch_wreq,
    input  logic [CH_NUM*ADDR_WIDTH-1:0]     ch_waddr,
    input  logic [CH_NUM*LEN_WIDTH-1:0]      ch_wr_len,
    input  logic [CH_NUM*8*DQ_WIDTH-1:0]     ch_wdata,
    input  logic [CH_NUM*CNT_WIDTH-1:0]      ch_fill,
    output logic [CH_NUM-1:0]                ch_wack,
    output logic [CH_NUM-1:0]                ch_wdata_req,
    output logic [CH_NUM-1:0]                ch_grant,
    output logic                             ddr_wreq,
    output logic [ADDR_WIDTH-1:0]            ddr_waddr,
    output logic [LEN_WIDTH-1:0]             ddr_wr_len,
    input  logic                             ddr_wrdy,
    input  logic                             ddr_wdata_req,
    output logic [8*DQ_WIDTH-1:0]            ddr_wdata,
    input  logic                             ddr_wdone,
    output logic                             arb_busy
);

    localparam int unsigned DW = 8 * DQ_WIDTH;

    arb_state_e                       state_q, state_d;
    logic [CH_NUM-1:0]                grant_q, grant_d;
    logic [CH_IDX_W-1:0]              grant_idx_q, grant_idx_d;
    logic [CH_IDX_W-1:0]              last_idx_q, last_idx_d;
    logic                             wreq_q, wreq_d;
    logic [ADDR_WIDTH-1:0]            waddr_q, waddr_d;
    logic [LEN_WIDTH-1:0]             len_q, len_d;
    logic [CH_NUM-1:0]                wack_q, wack_d;
    logic                             busy_q, busy_d;
    logic [CH_NUM-1:0][STARVE_W-1:0]  starve_q, starve_d;

    logic                             pick_any;
    logic [CH_NUM-1:0]                pick_oh;
    logic [CH_IDX_W-1:0]              pick_idx;

    ddr_wr_arb_pick #(
        .CH_NUM     (CH_NUM),
        .CNT_WIDTH  (CNT_WIDTH),
        .PRIO_CH    (PRIO_CH),
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .req        (ch_wreq),
        .fill       (ch_fill),
        .starve     (starve_q),
        .last_idx   (last_idx_q),
        .any_c      (pick_any),
        .win_oh_c   (pick_oh),
        .win_idx_c  (pick_idx)
    );

    // State and registered outputs.
    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            last_idx_q  <= CH_IDX_W'(CH_NUM - 1);
            wreq_q      <= 1'b0;
            waddr_q     <= '0;
            len_q       <= '0;
            wack_q      <= '0;
            busy_q      <= 1'b0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            last_idx_q  <= last_idx_d;
            wreq_q      <= wreq_d;
            waddr_q     <= waddr_d;
            len_q       <= len_d;
            wack_q      <= wack_d;
            busy_q      <= busy_d;
            starve_q    <= starve_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        last_idx_d  = last_idx_q;
        wreq_d      = wreq_q;
        waddr_d     = waddr_q;
        len_d       = len_q;
        wack_d      = '0;
        busy_d      = busy_q;
        starve_d    = starve_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d     = pick_oh;
                    grant_idx_d = pick_idx;
                    waddr_d     = ch_waddr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    len_d       = ch_wr_len[pick_idx*LEN_WIDTH +: LEN_WIDTH];
                    wreq_d      = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_REQ;
                    // Losers still requesting age; everyone else restarts.
                    for (int i = 0; i < int'(CH_NUM); i++) begin
                        if (pick_oh[i] || !ch_wreq[i]) begin
                            starve_d[i] = '0;
                        end else if (starve_q[i] != STARVE_W'(STARVE_MAX)) begin
                            starve_d[i] = starve_q[i] + STARVE_W'(1);
                        end
                    end
                end
            end
            ST_REQ: begin
                // A coincident ddr_wdone is ignored here.
                if (ddr_wrdy) begin
                    wreq_d  = 1'b0;
                    wack_d  = grant_q;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (ddr_wdone) begin
                    grant_d    = '0;
                    last_idx_d = grant_idx_q;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Data path is combinational from the registered grant.
    always_comb begin
        ddr_wdata = '0;
        if (|grant_q) begin
            ddr_wdata = ch_wdata[grant_idx_q*DW +: DW];
        end
        ch_wdata_req = (state_q == ST_DATA && ddr_wdata_req) ? grant_q : '0;
    end

    assign ch_grant   = grant_q;
    assign ch_wack    = wack_q;
    assign ddr_wreq   = wreq_q;
    assign ddr_waddr  = waddr_q;
    assign ddr_wr_len = len_q;
    assign arb_busy   = busy_q;

endmodule

// File: tb/tb_ddr_wr_arb.sv
// Scoreboard bench for ddr_wr_arb with a behavioural arbitration model.
module tb_ddr_wr_arb;

    localparam int CH_NUM     = 4;
    localparam int ADDR_WIDTH = 27;
    localparam int LEN_WIDTH  = 16;
    localparam int DQ_WIDTH   = 32;
    localparam int CNT_WIDTH  = 6;
    localparam int PRIO_CH    = 3;
    localparam int STARVE_MAX = 4;
    localparam int DW         = 8 * DQ_WIDTH;

    typedef struct {
        int                    idx;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
    } exp_t;

    logic                            ddr_clk = 1'b0;
    logic                            ddr_rst;
    logic [CH_NUM-1:0]               ch_wreq;
    logic [CH_NUM*ADDR_WIDTH-1:0]    ch_waddr;
    logic [CH_NUM*LEN_WIDTH-1:0]     ch_wr_len;
    logic [CH_NUM*DW-1:0]            ch_wdata;
    logic [CH_NUM*CNT_WIDTH-1:0]     ch_fill;
    logic [CH_NUM-1:0]               ch_wack;
    logic [CH_NUM-1:0]               ch_wdata_req;
    logic [CH_NUM-1:0]               ch_grant;
    logic                            ddr_wreq;
    logic [ADDR_WIDTH-1:0]           ddr_waddr;
    logic [LEN_WIDTH-1:0]            ddr_wr_len;
    logic                            ddr_wrdy;
    logic                            ddr_wdata_req;
    logic [DW-1:0]                   ddr_wdata;
    logic                            ddr_wdone;
    logic                            arb_busy;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    int   wack_q[$];

    // Reference model state.
    int m_starve[CH_NUM];
    int m_last;
    int fill_v[CH_NUM];
    logic [ADDR_WIDTH-1:0] addr_v[CH_NUM];
    logic [LEN_WIDTH-1:0]  len_v[CH_NUM];
    logic [DW-1:0]         data_v[CH_NUM];

    always #5 ddr_clk = ~ddr_clk;

    ddr_wr_arb #(
        .CH_NUM(CH_NUM), .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH),
        .DQ_WIDTH(DQ_WIDTH), .CNT_WIDTH(CNT_WIDTH), .PRIO_CH(PRIO_CH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .ddr_clk(ddr_clk), .ddr_rst(ddr_rst),
        .ch_wreq(ch_wreq), .ch_waddr(ch_waddr), .ch_wr_len(ch_wr_len),
        .ch_wdata(ch_wdata), .ch_fill(ch_fill),
        .ch_wack(ch_wack), .ch_wdata_req(ch_wdata_req), .ch_grant(ch_grant),
        .ddr_wreq(ddr_wreq), .ddr_waddr(ddr_waddr), .ddr_wr_len(ddr_wr_len),
        .ddr_wrdy(ddr_wrdy), .ddr_wdata_req(ddr_wdata_req),
        .ddr_wdata(ddr_wdata), .ddr_wdone(ddr_wdone), .arb_busy(arb_busy)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [CH_NUM-1:0] onehot(input int idx);
        logic [CH_NUM-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Winner from the arbitration rules: priority, starved, then max fill,
    // ties to the channel nearest after the last grant in rotation order.
    function automatic int model_pick(input logic [CH_NUM-1:0] mask);
        int best, bestd, win, d;
        best = -1; bestd = CH_NUM; win = -1;
        if (PRIO_CH < CH_NUM && mask[PRIO_CH]) return PRIO_CH;
        for (int i = 0; i < CH_NUM; i++)
            if (mask[i] && m_starve[i] == STARVE_MAX) return i;
        for (int i = 0; i < CH_NUM; i++) begin
            if (mask[i]) begin
                d = (i - m_last - 1 + 2*CH_NUM) % CH_NUM;
                if (fill_v[i] > best || (fill_v[i] == best && d < bestd)) begin
                    best = fill_v[i]; bestd = d; win = i;
                end
            end
        end
        return win;
    endfunction

    task automatic model_grant(input logic [CH_NUM-1:0] mask, input int w);
        for (int i = 0; i < CH_NUM; i++) begin
            if (i == w || !mask[i]) m_starve[i] = 0;
            else if (m_starve[i] < STARVE_MAX) m_starve[i] = m_starve[i] + 1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH_NUM; i++) m_starve[i] = 0;
        m_last = CH_NUM - 1;
        exp_q.delete();
        wack_q.delete();
    endtask

    // Monitor: checks each new burst request and each accept pulse.
    logic wreq_prev = 1'b0;
    always @(negedge ddr_clk) begin
        exp_t e;
        int   wi;
        if (ddr_rst) begin
            wreq_prev = 1'b0;
        end else begin
            if (ddr_wreq && !wreq_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_burst", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant", ch_grant, onehot(e.idx));
                    chk("waddr", ddr_waddr, e.addr);
                    chk("wr_len", ddr_wr_len, e.len);
                    chk("busy_req", arb_busy, 1);
                end
            end
            wreq_prev = ddr_wreq;
            if (ch_wack != '0) begin
                if (wack_q.size() == 0) begin
                    chk("unexpected_wack", ch_wack, 0);
                end else begin
                    wi = wack_q.pop_front();
                    chk("wack", ch_wack, onehot(wi));
                end
            end
        end
    end

    task automatic run_burst(input logic [CH_NUM-1:0] mask, input bit do_reset);
        int   w, lat;
        exp_t e;
        for (int i = 0; i < CH_NUM; i++) begin
            addr_v[i] = ADDR_WIDTH'($urandom);
            len_v[i]  = LEN_WIDTH'($urandom);
            for (int k = 0; k < 8; k++) data_v[i][k*32 +: 32] = $urandom;
            ch_waddr[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_v[i];
            ch_wr_len[i*LEN_WIDTH +: LEN_WIDTH]  = len_v[i];
            ch_wdata[i*DW +: DW]                 = data_v[i];
            ch_fill[i*CNT_WIDTH +: CNT_WIDTH]    = CNT_WIDTH'(fill_v[i]);
        end
        ch_wreq = mask;
        w = model_pick(mask);
        model_grant(mask, w);
        e.idx = w; e.addr = addr_v[w]; e.len = len_v[w];
        exp_q.push_back(e);
        wack_q.push_back(w);

        lat = 0;
        do begin
            @(negedge ddr_clk);
            lat++;
        end while (!ddr_wreq && lat < 10);
        chk("req_latency", lat, 1);

        // Requests and payload may change once latched.
        ch_wreq = '0;
        ch_waddr = {CH_NUM{27'h5a5a5a5}};
        repeat ($urandom_range(0, 2)) @(negedge ddr_clk);
        ddr_wdata_req = 1'b1;
        #1;
        chk("wdata_req_in_req", ch_wdata_req, 0);
        chk("addr_frozen", ddr_waddr, addr_v[w]);
        chk("wreq_held", ddr_wreq, 1);
        ddr_wdata_req = 1'b0;
        ddr_wrdy  = 1'b1;
        ddr_wdone = 1'($urandom_range(0, 1));
        @(negedge ddr_clk);
        ddr_wrdy  = 1'b0;
        ddr_wdone = 1'b0;
        chk("wreq_clear", ddr_wreq, 0);

        if (do_reset) begin
            ddr_rst = 1'b1;
            @(negedge ddr_clk);
            chk("rst_grant", ch_grant, 0);
            chk("rst_wack", ch_wack, 0);
            chk("rst_wreq", ddr_wreq, 0);
            chk("rst_addr", ddr_waddr, 0);
            chk("rst_len", ddr_wr_len, 0);
            chk("rst_busy", arb_busy, 0);
            chk("rst_wdata", ddr_wdata, 0);
            ddr_rst = 1'b0;
            model_reset();
            return;
        end

        @(negedge ddr_clk);
        chk("wack_one_cycle", ch_wack, 0);
        repeat (3) begin
            ddr_wdata_req = 1'($urandom_range(0, 1));
            #1;
            chk("wdata_req_route", ch_wdata_req, ddr_wdata_req ? onehot(w) : '0);
            chk("wdata_route", ddr_wdata, data_v[w]);
            chk("grant_held", ch_grant, onehot(w));
            @(negedge ddr_clk);
        end
        ddr_wdata_req = 1'b0;
        ddr_wdone     = 1'b1;
        @(negedge ddr_clk);
        ddr_wdone = 1'b0;
        m_last = w;
        chk("grant_release", ch_grant, 0);
        chk("busy_release", arb_busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [CH_NUM-1:0] m;
        ddr_rst = 1'b1;
        ch_wreq = '0; ch_waddr = '0; ch_wr_len = '0; ch_wdata = '0; ch_fill = '0;
        ddr_wrdy = 1'b0; ddr_wdata_req = 1'b0; ddr_wdone = 1'b0;
        model_reset();
        for (int i = 0; i < CH_NUM; i++) fill_v[i] = 0;
        repeat (3) @(negedge ddr_clk);
        chk("reset_wreq", ddr_wreq, 0);
        chk("reset_grant", ch_grant, 0);
        chk("reset_wack", ch_wack, 0);
        chk("reset_busy", arb_busy, 0);
        chk("reset_addr", ddr_waddr, 0);
        chk("reset_wdata", ddr_wdata, 0);
        ddr_rst = 1'b0;

        // Stray DDR handshakes in IDLE do nothing.
        ddr_wdone = 1'b1; ddr_wdata_req = 1'b1;
        @(negedge ddr_clk);
        chk("idle_wdata_req", ch_wdata_req, 0);
        ddr_wdone = 1'b0; ddr_wdata_req = 1'b0;
        @(negedge ddr_clk);
        chk("idle_no_req", ddr_wreq, 0);

        run_burst(4'b0010, 1'b0);

        fill_v = '{5, 9, 9, 0};
        repeat (3) run_burst(4'b0111, 1'b0);

        fill_v = '{63, 0, 0, 0};
        run_burst(4'b1001, 1'b0);

        fill_v = '{1, 60, 0, 0};
        repeat (6) run_burst(4'b0011, 1'b0);

        fill_v = '{7, 7, 7, 7};
        run_burst(4'b0111, 1'b1);
        run_burst(4'b0111, 1'b0);

        for (int n = 0; n < 40; n++) begin
            m = CH_NUM'($urandom_range(1, (1 << CH_NUM) - 1));
            if ($urandom_range(0, 2) != 0) m[PRIO_CH] = 1'b0;
            if (m == '0) m = 4'b0001;
            for (int i = 0; i < CH_NUM; i++)
                fill_v[i] = (n % 2 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 63);
            run_burst(m, (n == 20));
        end

        @(negedge ddr_clk);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("wack_q_empty", wack_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
